led_fade_sequencer: RTL

//  Upstream stage of the 8-LED PWM output driver. Generates a timed fade

---
 rtl/led_pkg.sv | 28 ++
 rtl/led_fade_sequencer_if.sv | 13 +
 rtl/tick_prescaler.sv | 34 +++
 rtl/led_fade_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED fade sequencer and the downstream PWM driver:
// phase encodings, PWM resolution and saturating level arithmetic.
package led_pkg;

    localparam int unsigned PWM_RESOLUTION = 8;

    typedef logic [PWM_RESOLUTION-1:0] level_t;

    localparam level_t PWM_MAX = '1;

    typedef enum logic [1:0] {
        FADE_UP   = 2'd0,
        HOLD_HIGH = 2'd1,
        FADE_DOWN = 2'd2,
        HOLD_LOW  = 2'd3
    } phase_e;

    function automatic level_t sat_add(level_t a, level_t b);
        logic [PWM_RESOLUTION:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PWM_RESOLUTION] ? PWM_MAX : sum[PWM_RESOLUTION-1:0];
    endfunction

    function automatic level_t sat_sub(level_t a, level_t b);
        return (a <= b) ? '0 : level_t'(a - b);
    endfunction

endpackage

// File: rtl/led_fade_sequencer_if.sv
// Valid/ready update channel from the fade sequencer to the PWM stage.
interface led_fade_sequencer_if;
    import led_pkg::*;

    logic       out_valid;
    logic       out_ready;
    level_t     brightness;
    logic [7:0] led_mask;

    modport master (output out_valid, output brightness, output led_mask, input out_ready);
    modport slave  (input out_valid, input brightness, input led_mask, output out_ready);

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every CLK_FREQ/STEP_HZ enabled cycles.
module tick_prescaler #(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned STEP_HZ  = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int unsigned PERIOD = CLK_FREQ / STEP_HZ;
    localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = enable && (cnt_q == LAST);
        cnt_d = '0;
        if (enable && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_fade_sequencer.sv
// Timed brightness fade pattern generator: ramp up, hold, ramp down, hold, invert mask,
// publishing each {brightness, led_mask} change over a valid/ready channel.
module led_fade_sequencer
    import led_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 25_000_000,
    parameter int unsigned STEP_HZ   = 100,
    parameter logic [7:0]  INIT_MASK = 8'h55
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [7:0]             step_size,
    input  logic [15:0]            hold_ticks,
    input  logic                   mask_load,
    input  logic [7:0]             mask_in,
    led_fade_sequencer_if.master   out_if,
    output logic [1:0]             phase
);

    logic        tick;
    phase_e      phase_q, phase_d;
    level_t      bright_q, bright_d;
    logic [7:0]  mask_q, mask_d;
    logic        valid_q, valid_d;
    logic [15:0] hold_q, hold_d;
    logic        pend_tick_q, pend_tick_d;
    logic        pend_load_q, pend_load_d;
    logic [7:0]  pend_mask_q, pend_mask_d;

    logic        free;
    logic        emit;
    logic        hold_done;
    level_t      step_eff;

    tick_prescaler #(
        .CLK_FREQ (CLK_FREQ),
        .STEP_HZ  (STEP_HZ)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= FADE_UP;
            bright_q    <= '0;
            mask_q      <= INIT_MASK;
            valid_q     <= 1'b0;
            hold_q      <= '0;
            pend_tick_q <= 1'b0;
            pend_load_q <= 1'b0;
            pend_mask_q <= '0;
        end else begin
            phase_q     <= phase_d;
            bright_q    <= bright_d;
            mask_q      <= mask_d;
            valid_q     <= valid_d;
            hold_q      <= hold_d;
            pend_tick_q <= pend_tick_d;
            pend_load_q <= pend_load_d;
            pend_mask_q <= pend_mask_d;
        end
    end

    always_comb begin
        free      = !valid_q || out_if.out_ready;
        step_eff  = (step_size == '0) ? level_t'(1) : step_size;
        hold_done = ({1'b0, hold_q} + 17'd1) >= {1'b0, hold_ticks};

        phase_d     = phase_q;
        bright_d    = bright_q;
        mask_d      = mask_q;
        valid_d     = valid_q;
        hold_d      = hold_q;
        pend_tick_d = pend_tick_q;
        pend_load_d = pend_load_q;
        pend_mask_d = pend_mask_q;
        emit        = 1'b0;

        if (free) begin
            // A load restarts the sequence, so a coincident or pending tick is discarded.
            if (mask_load || pend_load_q) begin
                mask_d      = mask_load ? mask_in : pend_mask_q;
                bright_d    = '0;
                phase_d     = FADE_UP;
                hold_d      = '0;
                pend_load_d = 1'b0;
                pend_tick_d = 1'b0;
                emit        = 1'b1;
            end else if (enable && (tick || pend_tick_q)) begin
                pend_tick_d = 1'b0;
                unique case (phase_q)
                    FADE_UP: begin
                        bright_d = sat_add(bright_q, step_eff);
                        if (bright_d == PWM_MAX) begin
                            phase_d = HOLD_HIGH;
                            hold_d  = '0;
                        end
                        emit = 1'b1;
                    end
                    HOLD_HIGH: begin
                        if (hold_done) phase_d = FADE_DOWN;
                        else           hold_d  = hold_q + 16'd1;
                    end
                    FADE_DOWN: begin
                        bright_d = sat_sub(bright_q, step_eff);
                        if (bright_d == '0) begin
                            phase_d = HOLD_LOW;
                            hold_d  = '0;
                        end
                        emit = 1'b1;
                    end
                    HOLD_LOW: begin
                        if (hold_done) begin
                            phase_d = FADE_UP;
                            mask_d  = ~mask_q;
                            emit    = 1'b1;
                        end else begin
                            hold_d = hold_q + 16'd1;
                        end
                    end
                endcase
            end
            valid_d = emit;
        end else begin
            if (mask_load) begin
                pend_load_d = 1'b1;
                pend_mask_d = mask_in;
            end
            if (tick) pend_tick_d = 1'b1;
        end
    end

    always_comb begin
        out_if.out_valid  = valid_q;
        out_if.brightness = bright_q;
        out_if.led_mask   = mask_q;
        phase             = phase_q;
    end

endmodule
